// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: load op codes,
// stall polarity, default stall width and the response-tracking FSM encoding.
package mem_stage_lsu_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int STALL_W_DEF = 6;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [2:0] LD_LD  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-lane extraction, sign/zero extension and misalignment
// detection for a DATA_W-wide memory word.
module lsu_load_align
    import mem_stage_lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [2:0]        ld_op,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [DATA_W-1:0] shifted;

    // Bring the addressed byte lane down to bit 0; narrow ops then take the low bits.
    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        data     = DATA_W'($signed(shifted[31:0]));
        misalign = (off[1:0] != 2'b00);
        case (ld_op)
            LD_LB: begin
                data     = DATA_W'($signed(shifted[7:0]));
                misalign = 1'b0;
            end
            LD_LBU: begin
                data     = DATA_W'(shifted[7:0]);
                misalign = 1'b0;
            end
            LD_LH: begin
                data     = DATA_W'($signed(shifted[15:0]));
                misalign = off[0];
            end
            LD_LHU: begin
                data     = DATA_W'(shifted[15:0]);
                misalign = off[0];
            end
            LD_LD: begin
                // On a 32-bit datapath LD falls back to the LW defaults above.
                if (DATA_W == 64) begin
                    data     = rdata;
                    misalign = (off != '0);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with a variable-latency data-memory response: holds the
// EX->MEM register, tracks the outstanding load, drives WB and the ID forward bus.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int RA_W    = 5,
    parameter int STALL_W = STALL_W_DEF,
    parameter int MEM_IDX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               ex_valid,
    input  logic [PC_W-1:0]    ex_pc,
    input  logic               ex_ld,
    input  logic [2:0]         ex_ld_op,
    input  logic               ex_rf_we,
    input  logic [RA_W-1:0]    ex_rf_waddr,
    input  logic [DATA_W-1:0]  ex_result,
    input  logic [DATA_W-1:0]  data_rdata,
    input  logic               data_ok,
    output logic               mem_stallreq,
    output logic               ld_misalign,
    output logic               wb_valid,
    output logic [PC_W-1:0]    wb_pc,
    output logic               wb_rf_we,
    output logic [RA_W-1:0]    wb_rf_waddr,
    output logic [DATA_W-1:0]  wb_rf_wdata,
    output logic               fwd_we,
    output logic [RA_W-1:0]    fwd_waddr,
    output logic [DATA_W-1:0]  fwd_wdata,
    output logic               fwd_pending
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              valid_reg;
    logic [PC_W-1:0]   pc_reg;
    logic              ld_reg;
    logic [2:0]        ld_op_reg;
    logic              rf_we_reg;
    logic [RA_W-1:0]   rf_waddr_reg;
    logic [DATA_W-1:0] result_reg;
    logic [DATA_W-1:0] rdata_buf_reg, rdata_buf_next;
    lsu_state_e        state_reg, state_next;

    logic              capture, bubble;
    logic              wait_nok, ld_slot, align_mis;
    logic [DATA_W-1:0] raw_data, ld_data;
    logic              stall_unused;

    // Only this stage's bit and the WB bit matter here.
    assign stall_unused = ^stall;

    assign bubble  = (stall[MEM_IDX] == STOP) && (stall[MEM_IDX+1] == NO_STOP);
    assign capture = (stall[MEM_IDX] == NO_STOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg    <= 1'b0;
            pc_reg       <= '0;
            ld_reg       <= 1'b0;
            ld_op_reg    <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            result_reg   <= '0;
        end else if (bubble) begin
            valid_reg    <= 1'b0;
            pc_reg       <= '0;
            ld_reg       <= 1'b0;
            ld_op_reg    <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            result_reg   <= '0;
        end else if (capture) begin
            valid_reg    <= ex_valid;
            pc_reg       <= ex_pc;
            ld_reg       <= ex_ld;
            ld_op_reg    <= ex_ld_op;
            rf_we_reg    <= ex_rf_we;
            rf_waddr_reg <= ex_rf_waddr;
            result_reg   <= ex_result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            rdata_buf_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rdata_buf_reg <= rdata_buf_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rdata_buf_next = rdata_buf_reg;
        if (capture) begin
            state_next = (ex_valid && ex_ld) ? WAIT : IDLE;
        end else if (bubble) begin
            state_next = IDLE;
        end else if ((state_reg == WAIT) && data_ok) begin
            state_next     = DONE;
            rdata_buf_next = data_rdata;
        end
    end

    // Responses seen in IDLE/DONE are strays; only WAIT looks at data_rdata.
    assign raw_data = (state_reg == DONE) ? rdata_buf_reg : data_rdata;

    lsu_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .ld_op    (ld_op_reg),
        .off      (result_reg[OFF_W-1:0]),
        .rdata    (raw_data),
        .data     (ld_data),
        .misalign (align_mis)
    );

    assign wait_nok     = (state_reg == WAIT) && !data_ok;
    assign ld_slot      = valid_reg && ld_reg;

    assign mem_stallreq = wait_nok;
    assign ld_misalign  = ld_slot && align_mis;
    assign wb_valid     = valid_reg && !wait_nok;
    assign wb_pc        = pc_reg;
    assign wb_rf_we     = rf_we_reg && !wait_nok && !ld_misalign;
    assign wb_rf_waddr  = rf_waddr_reg;
    assign wb_rf_wdata  = ld_slot ? ld_data : result_reg;

    assign fwd_we       = rf_we_reg && !ld_misalign;
    assign fwd_waddr    = rf_waddr_reg;
    assign fwd_wdata    = wb_rf_wdata;
    assign fwd_pending  = wait_nok && !ld_misalign;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu (32- and 64-bit instances) and the standalone aligner.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  stall_ext, stall32, stall64;
    logic        ex_valid, ex_ld, ex_rf_we, data_ok;
    logic [31:0] ex_pc;
    logic [2:0]  ex_ld_op;
    logic [4:0]  ex_rf_waddr;
    logic [63:0] ex_result, data_rdata;

    logic        stallreq32, mis32, valid32, we32, fwe32, pend32;
    logic [31:0] pc32, wdata32, fwdd32;
    logic [4:0]  waddr32, fwaddr32;
    logic        stallreq64, mis64, valid64, we64, fwe64, pend64;
    logic [31:0] pc64;
    logic [63:0] wdata64, fwdd64;
    logic [4:0]  waddr64, fwaddr64;

    // Emulated stall controller: a MEM stall request freezes IF..MEM.
    assign stall32 = stall_ext | (stallreq32 ? 6'b011111 : 6'b000000);
    assign stall64 = stall_ext | (stallreq64 ? 6'b011111 : 6'b000000);

    mem_stage_lsu #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst), .stall(stall32), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_ld(ex_ld), .ex_ld_op(ex_ld_op), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_result(ex_result[31:0]), .data_rdata(data_rdata[31:0]), .data_ok(data_ok),
        .mem_stallreq(stallreq32), .ld_misalign(mis32), .wb_valid(valid32), .wb_pc(pc32),
        .wb_rf_we(we32), .wb_rf_waddr(waddr32), .wb_rf_wdata(wdata32), .fwd_we(fwe32),
        .fwd_waddr(fwaddr32), .fwd_wdata(fwdd32), .fwd_pending(pend32));

    mem_stage_lsu #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .stall(stall64), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_ld(ex_ld), .ex_ld_op(ex_ld_op), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_result(ex_result), .data_rdata(data_rdata), .data_ok(data_ok),
        .mem_stallreq(stallreq64), .ld_misalign(mis64), .wb_valid(valid64), .wb_pc(pc64),
        .wb_rf_we(we64), .wb_rf_waddr(waddr64), .wb_rf_wdata(wdata64), .fwd_we(fwe64),
        .fwd_waddr(fwaddr64), .fwd_wdata(fwdd64), .fwd_pending(pend64));

    logic [2:0]  al_op, al_off;
    logic [63:0] al_rdata, al_data64;
    logic [31:0] al_data32;
    logic        al_mis32, al_mis64;

    lsu_load_align #(.DATA_W(32)) align32 (
        .ld_op(al_op), .off(al_off[1:0]), .rdata(al_rdata[31:0]), .data(al_data32), .misalign(al_mis32));
    lsu_load_align #(.DATA_W(64)) align64 (
        .ld_op(al_op), .off(al_off), .rdata(al_rdata), .data(al_data64), .misalign(al_mis64));

    bit          sel64;
    logic        s_stallreq, s_mis, s_valid, s_we, s_fwe, s_pend;
    logic [31:0] s_pc;
    logic [4:0]  s_waddr, s_fwaddr;
    logic [63:0] s_wdata, s_fwdd;
    assign s_stallreq = sel64 ? stallreq64 : stallreq32;
    assign s_mis      = sel64 ? mis64      : mis32;
    assign s_valid    = sel64 ? valid64    : valid32;
    assign s_we       = sel64 ? we64       : we32;
    assign s_fwe      = sel64 ? fwe64      : fwe32;
    assign s_pend     = sel64 ? pend64     : pend32;
    assign s_pc       = sel64 ? pc64       : pc32;
    assign s_waddr    = sel64 ? waddr64    : waddr32;
    assign s_fwaddr   = sel64 ? fwaddr64   : fwaddr32;
    assign s_wdata    = sel64 ? wdata64    : {32'b0, wdata32};
    assign s_fwdd     = sel64 ? fwdd64     : {32'b0, fwdd32};

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: gather the addressed bytes, then extend to the datapath width.
    function automatic logic [64:0] ref_align(input int dw, input logic [2:0] op,
                                              input int off, input logic [63:0] rd);
        int nb;
        bit sx;
        logic [63:0] v;
        case (op)
            3'd1:    begin nb = 1; sx = 1; end
            3'd2:    begin nb = 1; sx = 0; end
            3'd3:    begin nb = 2; sx = 1; end
            3'd4:    begin nb = 2; sx = 0; end
            3'd5:    begin nb = (dw == 64) ? 8 : 4; sx = 1; end
            default: begin nb = 4; sx = 1; end
        endcase
        v = '0;
        for (int b = 0; b < nb; b++)
            if (off + b < dw / 8) v[8*b +: 8] = rd[8*(off+b) +: 8];
        if (sx && v[8*nb-1])
            for (int b = 8 * nb; b < dw; b++) v[b] = 1'b1;
        return {((off % nb) != 0), v};
    endfunction

    task automatic load_txn(input bit w64, input logic [2:0] op, input logic [63:0] addr,
                            input bit we, input logic [4:0] wa, input logic [63:0] rd,
                            input int lat, input string tag);
        logic [64:0] r;
        logic [31:0] pc;
        int off;
        off = w64 ? int'(addr[2:0]) : int'(addr[1:0]);
        r   = ref_align(w64 ? 64 : 32, op, off, rd);
        pc  = $urandom;
        sel64 = w64;
        ex_valid = 1; ex_ld = 1; ex_ld_op = op; ex_rf_we = we; ex_rf_waddr = wa;
        ex_pc = pc; ex_result = addr; stall_ext = '0;
        @(posedge clk); #1;
        ex_valid = 0; ex_ld = 0; ex_rf_we = 0;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk({tag, " wait stallreq"}, 64'(s_stallreq), 64'd1);
            chk({tag, " wait pending"}, 64'(s_pend), 64'(!r[64]));
            chk({tag, " wait wb_valid"}, 64'(s_valid), 64'd0);
            chk({tag, " wait wb_rf_we"}, 64'(s_we), 64'd0);
            @(posedge clk); #1;
        end
        data_ok = 1; data_rdata = rd;
        @(negedge clk);
        chk({tag, " ok stallreq"}, 64'(s_stallreq), 64'd0);
        chk({tag, " ok pending"}, 64'(s_pend), 64'd0);
        chk({tag, " ok wb_valid"}, 64'(s_valid), 64'd1);
        chk({tag, " ok misalign"}, 64'(s_mis), 64'(r[64]));
        chk({tag, " ok wb_rf_we"}, 64'(s_we), 64'(we && !r[64]));
        chk({tag, " ok fwd_we"}, 64'(s_fwe), 64'(we && !r[64]));
        chk({tag, " ok waddr"}, 64'({s_waddr, s_fwaddr}), 64'({wa, wa}));
        chk({tag, " ok pc"}, 64'(s_pc), 64'(pc));
        if (!r[64]) begin
            chk({tag, " ok wdata"}, s_wdata, r[63:0]);
            chk({tag, " ok fwd_wdata"}, s_fwdd, r[63:0]);
        end
        $display("load w64=%0d op=%0d addr=%h lat=%0d rdata=%h -> wdata=%h mis=%0d",
                 w64, op, addr, lat, rd, s_wdata, s_mis);
        @(posedge clk); #1;
        data_ok = 0;
    endtask

    task automatic alu_txn(input bit w64, input logic [63:0] res, input bit we, input logic [4:0] wa);
        logic [63:0] exp;
        exp = w64 ? res : {32'b0, res[31:0]};
        sel64 = w64;
        ex_valid = 1; ex_ld = 0; ex_ld_op = 3'($urandom); ex_rf_we = we; ex_rf_waddr = wa;
        ex_result = res; stall_ext = '0;
        @(posedge clk); #1;
        ex_valid = 0; ex_rf_we = 0;
        @(negedge clk);
        chk("alu flags", 64'({s_valid, s_we, s_fwe, s_stallreq, s_pend, s_mis}),
            64'({1'b1, we, we, 3'b000}));
        chk("alu wdata", s_wdata, exp);
        chk("alu fwd_wdata", s_fwdd, exp);
        $display("alu w64=%0d result=%h we=%0d -> wdata=%h", w64, res, we, s_wdata);
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " flags32"}, 64'({stallreq32, mis32, valid32, we32, fwe32, pend32}), 64'd0);
        chk({tag, " flags64"}, 64'({stallreq64, mis64, valid64, we64, fwe64, pend64}), 64'd0);
        chk({tag, " data32"}, {wdata32, fwdd32}, 64'd0);
        chk({tag, " data64"}, wdata64 | fwdd64, 64'd0);
        chk({tag, " pc/addr"}, 64'({pc32, pc64}) | 64'({waddr32, fwaddr32, waddr64, fwaddr64}), 64'd0);
    endtask

    typedef struct {
        bit          w64;
        logic [2:0]  op;
        logic [2:0]  off;
        logic [63:0] rd;
        logic [63:0] exp;
        bit          mis;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{0, LD_LB,  3'd3, 64'h80112233, 64'hFFFFFF80, 0};
        vecs[1]  = '{0, LD_LBU, 3'd3, 64'h80112233, 64'h00000080, 0};
        vecs[2]  = '{0, LD_LHU, 3'd2, 64'h80112233, 64'h00008011, 0};
        vecs[3]  = '{0, LD_LH,  3'd2, 64'h80112233, 64'hFFFF8011, 0};
        vecs[4]  = '{0, LD_LH,  3'd1, 64'h80112233, 64'h0, 1};
        vecs[5]  = '{0, LD_LW,  3'd0, 64'hDEADBEEF, 64'hDEADBEEF, 0};
        vecs[6]  = '{0, LD_LW,  3'd2, 64'hDEADBEEF, 64'h0, 1};
        vecs[7]  = '{0, LD_LD,  3'd0, 64'h12345678, 64'h12345678, 0};
        vecs[8]  = '{1, LD_LD,  3'd0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0};
        vecs[9]  = '{1, LD_LW,  3'd4, 64'h80000000_11223344, 64'hFFFFFFFF80000000, 0};
        vecs[10] = '{1, LD_LD,  3'd4, 64'h0123456789ABCDEF, 64'h0, 1};
        vecs[11] = '{1, LD_LHU, 3'd6, 64'hABCD0000_00000000, 64'h000000000000ABCD, 0};
        vecs[12] = '{1, LD_LB,  3'd7, 64'h7F000000_00000000, 64'h000000000000007F, 0};

        rst = 0; stall_ext = '0; data_ok = 0; data_rdata = '0; sel64 = 0;
        ex_valid = 0; ex_ld = 0; ex_ld_op = '0; ex_rf_we = 0; ex_rf_waddr = '0;
        ex_pc = '0; ex_result = '0;
        al_op = '0; al_off = '0; al_rdata = '0;
        #12;
        chk_zero("reset");

        for (int i = 0; i < 13; i++) begin
            al_op = vecs[i].op; al_off = vecs[i].off; al_rdata = vecs[i].rd;
            #1;
            if (vecs[i].w64) begin
                chk($sformatf("vec%0d mis", i), 64'(al_mis64), 64'(vecs[i].mis));
                if (!vecs[i].mis) chk($sformatf("vec%0d data", i), al_data64, vecs[i].exp);
            end else begin
                chk($sformatf("vec%0d mis", i), 64'(al_mis32), 64'(vecs[i].mis));
                if (!vecs[i].mis) chk($sformatf("vec%0d data", i), {32'b0, al_data32}, vecs[i].exp);
            end
            $display("vec%0d w64=%0d op=%0d off=%0d -> d32=%h d64=%h", i, vecs[i].w64,
                     vecs[i].op, vecs[i].off, al_data32, al_data64);
        end

        for (int i = 0; i < 100; i++) begin
            logic [64:0] r32, r64;
            al_op = 3'($urandom); al_off = 3'($urandom); al_rdata = {$urandom, $urandom};
            #1;
            r32 = ref_align(32, al_op, int'(al_off[1:0]), al_rdata);
            r64 = ref_align(64, al_op, int'(al_off), al_rdata);
            chk("rnd align mis32", 64'(al_mis32), 64'(r32[64]));
            chk("rnd align mis64", 64'(al_mis64), 64'(r64[64]));
            if (!r32[64]) chk("rnd align data32", {32'b0, al_data32}, r32[63:0]);
            if (!r64[64]) chk("rnd align data64", al_data64, r64[63:0]);
        end

        @(posedge clk); #1;
        rst = 1;

        load_txn(0, LD_LW,  64'h100, 1, 5'd4, 64'hDEADBEEF, 3, "lw100");
        load_txn(0, LD_LB,  64'h103, 1, 5'd5, 64'h80112233, 2, "lb");
        load_txn(0, LD_LBU, 64'h103, 1, 5'd6, 64'h80112233, 1, "lbu");
        load_txn(0, LD_LHU, 64'h102, 1, 5'd7, 64'h80112233, 2, "lhu");
        load_txn(0, LD_LH,  64'h101, 1, 5'd8, 64'h80112233, 2, "lh_mis");
        load_txn(1, LD_LD,  64'h8,   1, 5'd9, 64'h0123456789ABCDEF, 2, "ld64");
        load_txn(1, LD_LW,  64'hC,   1, 5'd10, 64'h80000000_55667788, 1, "lw64");

        // Response while WB is stalled: buffered, then a stray response is ignored.
        sel64 = 0;
        ex_valid = 1; ex_ld = 1; ex_ld_op = LD_LW; ex_rf_we = 1; ex_rf_waddr = 5'd7;
        ex_result = 64'h200; stall_ext = '0;
        @(posedge clk); #1;
        ex_valid = 0; ex_ld = 0; ex_rf_we = 0;
        @(posedge clk); #1;
        data_ok = 1; data_rdata = 64'hCAFEF00D; stall_ext = 6'b011111;
        @(negedge clk);
        chk("done ok wdata", s_wdata, 64'hCAFEF00D);
        @(posedge clk); #1;
        data_rdata = 64'h12345678;
        @(negedge clk);
        chk("done state", 64'(dut32.state_reg), 64'd2);
        chk("done stray wdata", s_wdata, 64'hCAFEF00D);
        chk("done flags", 64'({s_valid, s_we, s_stallreq, s_pend}), 64'b1100);
        $display("done-hold stray rdata=12345678 -> wdata=%h", s_wdata);
        @(posedge clk); #1;
        data_ok = 0;
        @(negedge clk);
        chk("done held wdata", s_wdata, 64'hCAFEF00D);
        stall_ext = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("done release", 64'({s_valid, 2'(dut32.state_reg)}), 64'd0);

        // Hold versus bubble on an ALU op.
        ex_valid = 1; ex_ld = 0; ex_rf_we = 1; ex_rf_waddr = 5'd3; ex_result = 64'h55;
        @(posedge clk); #1;
        ex_result = 64'h99; stall_ext = 6'b011000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold slot", {s_wdata[31:0], 24'b0, 3'(s_waddr), s_valid, s_we, s_fwe, s_pend, s_stallreq},
            {32'h55, 24'b0, 3'd3, 5'b11100});
        stall_ext = 6'b001000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bubble flags", 64'({s_valid, s_we, s_fwe}), 64'd0);
        chk("bubble wdata", s_wdata, 64'd0);
        $display("hold/bubble wb_valid=%0d wdata=%h", s_valid, s_wdata);
        stall_ext = '0; ex_valid = 0; ex_rf_we = 0;

        // Reset pulsed mid-WAIT, then a late response.
        ex_valid = 1; ex_ld = 1; ex_ld_op = LD_LW; ex_rf_we = 1; ex_rf_waddr = 5'd12;
        ex_result = 64'h300;
        @(posedge clk); #1;
        ex_valid = 0; ex_ld = 0; ex_rf_we = 0;
        @(negedge clk);
        chk("rstwait stallreq", 64'(s_stallreq), 64'd1);
        #2 rst = 0;
        #1;
        chk_zero("rst async");
        chk("rst state", 64'(dut32.state_reg), 64'd0);
        @(posedge clk); #1;
        rst = 1; data_ok = 1; data_rdata = 64'hA5A5A5A5;
        @(negedge clk);
        chk_zero("rst late ok");
        @(posedge clk); #1;
        data_ok = 0;
        @(negedge clk);
        chk("rst after state", 64'({2'(dut32.state_reg), 2'(dut64.state_reg)}), 64'd0);
        chk("rst after buf", 64'(dut32.rdata_buf_reg), 64'd0);
        $display("reset mid-wait -> state=%0d wdata=%h", dut32.state_reg, s_wdata);

        for (int k = 0; k < 80; k++) begin
            bit w;
            w = 1'($urandom);
            if ($urandom_range(0, 3) == 0)
                alu_txn(w, {$urandom, $urandom}, 1'($urandom), 5'($urandom));
            else
                load_txn(w, 3'($urandom), {$urandom, $urandom}, 1'($urandom), 5'($urandom),
                         {$urandom, $urandom}, $urandom_range(1, 4), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the single-cycle MEM stage.
- Holds the EX->MEM pipeline register and waits for a variable-latency data-memory response (data_ok) instead of assuming same-cycle read data.
- Extracts and extends load lanes for any DATA_W, flags misaligned loads, and raises a stall request while a load is outstanding.
- Drives the WB bus, plus a forwarding bus to ID with a "pending" flag so ID can interlock on load-use.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- PC_W, 32, PC width.
- RA_W, 5, register address width.
- STALL_W, 6, stall vector width.
- MEM_IDX, 3, index of this stage's bit in stall; bit MEM_IDX+1 is WB.

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-low.
- stall in STALL_W: pipeline stall vector; `Stop = 1.
- ex_valid in 1: EX slot holds a real instruction.
- ex_pc in PC_W: instruction PC.
- ex_ld in 1: instruction is a load whose request was issued in EX.
- ex_ld_op in 3: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LD (legal only when DATA_W=64), others treated as LW.
- ex_rf_we in 1: register write enable.
- ex_rf_waddr in RA_W: destination register.
- ex_result in DATA_W: ALU result / effective address.
- data_rdata in DATA_W: memory read data, valid when data_ok=1.
- data_ok in 1: one-cycle response strobe.
- mem_stallreq out 1: request to stall IF..MEM.
- ld_misalign out 1: misaligned-load flag for the current MEM slot.
- wb_valid out 1: WB slot valid.
- wb_pc out PC_W: PC to WB.
- wb_rf_we out 1: register write enable to WB.
- wb_rf_waddr out RA_W: destination register to WB.
- wb_rf_wdata out DATA_W: write data to WB.
- fwd_we out 1: forwarding write enable to ID.
- fwd_waddr out RA_W: forwarding destination register.
- fwd_wdata out DATA_W: forwarding data.
- fwd_pending out 1: fwd_wdata is not yet valid (load outstanding); ID must stall on a match.

Behaviour:
- Reset (rst=0, asynchronous): pipeline register cleared, FSM=IDLE, rdata buffer cleared. All outputs 0.
- Pipeline register update on posedge clk, in priority order:
  - stall[MEM_IDX]=1 and stall[MEM_IDX+1]=0: load a bubble (all fields 0).
  - else stall[MEM_IDX]=0: capture ex_* fields.
  - else: hold.
- FSM states: IDLE, WAIT, DONE.
  - Any state: a capture with ex_valid&ex_ld goes to WAIT; any other capture or a bubble goes to IDLE.
  - WAIT with data_ok=1: latch data_rdata into the buffer, go to DONE. This takes priority only when no capture happens in the same cycle; a capture requires stall[MEM_IDX]=0, which is impossible in WAIT because mem_stallreq is asserted.
  - DONE: hold until the next capture or bubble.
- data_ok in IDLE or DONE is a stray response: ignored, buffer unchanged.
- data_ok arriving in the capture cycle itself is not allowed; the earliest legal response is 1 cycle after capture.
- mem_stallreq = (state==WAIT) & ~data_ok. It is combinational, so a response releases the stall in the same cycle.
- Load data source:
  - WAIT with data_ok: data_rdata.
  - DONE: the buffer.
  - Lane extraction: off = ex_result[log2(DATA_W/8)-1:0].
  - Byte: lane off*8. Half: lane off*8 (off even). Word: lane off*8 (off multiple of 4). LD: full width.
  - LB/LH/(LW when DATA_W=64) sign-extend; LBU/LHU zero-extend.
- Misalignment: ld_misalign=1 when the slot is a valid load and any of:
  - half with off[0]=1;
  - word with off[1:0]!=0;
  - LD with off!=0.
  - When set, wb_rf_we=0, fwd_we=0, fwd_pending=0, and mem_stallreq is still governed by the FSM.
- wb_rf_wdata = extracted load data for a valid load, else the registered ex_result.
- wb_valid = registered ex_valid & ~(state==WAIT & ~data_ok). wb_rf_we is gated the same way.
- Forwarding:
  - fwd_we = registered rf_we & ~ld_misalign.
  - fwd_waddr = registered rf_waddr.
  - fwd_wdata = wb_rf_wdata.
  - fwd_pending = (state==WAIT) & ~data_ok.
- Reset asserted during WAIT returns the FSM to IDLE; a late data_ok after reset is ignored.

Decomposition:
- Shared package defines:
  - ld_op encodings;
  - `Stop/`NoStop;
  - STALL_W default;
  - FSM state encoding IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
- One sub-module, lsu_load_align: combinational lane extraction, extension and misalign detection, parametrised by DATA_W. Verify it standalone as well.

Test Plan:
- DATA_W=32, LW @0x100, data_ok 3 cycles after capture with rdata=0xDEADBEEF:
  - mem_stallreq and fwd_pending are 1 for 2 cycles, 0 in the data_ok cycle.
  - wb_rf_wdata=0xDEADBEEF, wb_rf_we=1 in the data_ok cycle.
- LB with addr[1:0]=2'b11, rdata=0x80112233 -> wdata=0xFFFFFF80. LBU, same inputs -> 0x00000080. LHU with addr[1:0]=2'b10 -> 0x00008011.
- LH @ odd address 0x101 -> ld_misalign=1, wb_rf_we=0, fwd_we=0.
- data_ok arrives while stall[MEM_IDX+1]=1 (WB stalled) -> FSM goes to DONE. While held, the buffered value is presented on wb_rf_wdata. A stray data_ok with rdata=0x12345678 in DONE does not change wdata.
- stall[3]=1, stall[4]=0 on a non-load ALU op -> next cycle wb_valid=0, wb_rf_we=0. stall[3]=stall[4]=1 -> slot held unchanged.
- DATA_W=64, LD @0x8, rdata=0x0123456789ABCDEF -> full value forwarded. LW at off=4 with rdata[63:32]=0x80000000 -> 0xFFFFFFFF80000000.
- rst pulsed low mid-WAIT, followed by a data_ok -> all outputs 0, FSM=IDLE, no write.
